// File: rtl/phy_tx_serializer.sv
// Transmit-side PHY serializer.
// Round-robin multiplexes four 8-bit lanes onto one serial line, MSB first,
// one bit per clk_32f cycle. Empty slots and the start-up/re-enable preamble
// carry IDLE_BYTE so the far-end receiver can lock before data arrives.
module phy_tx_serializer #(
   parameter int         SYNC_BYTES = 4,
   parameter logic [7:0] IDLE_BYTE  = 8'hBC
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] data_in_0,
   input  logic [7:0] data_in_1,
   input  logic [7:0] data_in_2,
   input  logic [7:0] data_in_3,
   input  logic       valid_in_0,
   input  logic       valid_in_1,
   input  logic       valid_in_2,
   input  logic       valid_in_3,
   output logic       data_serial,
   output logic [3:0] lane_ack,
   output logic       active_out
);

   typedef enum logic {SYNC = 1'b0, DATA = 1'b1} state_t;

   // Terminal preamble count: the load that sends the last idle byte of the
   // preamble is also the edge that enters DATA.
   localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES - 1);

   state_t      state;
   logic [7:0]  shift_reg;
   logic [2:0]  bit_cnt;
   logic [1:0]  slot;
   logic [3:0]  sync_cnt;

   // Lane inputs gathered into arrays so the current slot can index them.
   logic [7:0]  lane_data [4];
   logic [3:0]  lane_valid;
   logic [3:0]  slot_onehot;

   logic        load;
   logic        take;
   logic [7:0]  next_byte;
   logic [3:0]  next_ack;

   // Flatten the individual lane ports into indexable arrays.
   always_comb begin
      lane_data[0] = data_in_0;
      lane_data[1] = data_in_1;
      lane_data[2] = data_in_2;
      lane_data[3] = data_in_3;
      lane_valid   = {valid_in_3, valid_in_2, valid_in_1, valid_in_0};
   end

   // One-hot decode of the current slot, used to form the ack pulse.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slot_dec
         assign slot_onehot[gi] = (slot == 2'(gi));
      end
   endgenerate

   // Byte selection for the coming load edge. A lane is only taken in DATA
   // with enable high; everything else sends the idle byte.
   always_comb begin
      load      = (bit_cnt == 3'd0);
      take      = (state == DATA) && enable && lane_valid[slot];
      next_byte = take ? lane_data[slot] : IDLE_BYTE;
      next_ack  = take ? slot_onehot : 4'b0000;
   end

   // Serializer datapath, slot rotation and SYNC/DATA control in one process.
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         data_serial <= 1'b0;
         lane_ack    <= 4'b0000;
         active_out  <= 1'b0;
         bit_cnt     <= 3'd0;
         slot        <= 2'd0;
         sync_cnt    <= 4'd0;
         shift_reg   <= 8'h00;
         state       <= SYNC;
      end else begin
         // Ack is a single-cycle pulse; only a DATA load can raise it.
         lane_ack <= 4'b0000;
         if (load) begin
            data_serial <= next_byte[7];
            shift_reg   <= {next_byte[6:0], 1'b0};
            bit_cnt     <= 3'd1;
            case (state)
               SYNC: begin
                  slot <= 2'd0;
                  if (enable) begin
                     if (sync_cnt == SYNC_LAST) begin
                        state      <= DATA;
                        sync_cnt   <= 4'd0;
                        active_out <= 1'b1;
                     end else begin
                        sync_cnt <= sync_cnt + 4'd1;
                     end
                  end else begin
                     // Preamble restarts from scratch while disabled.
                     sync_cnt <= 4'd0;
                  end
               end
               DATA: begin
                  if (enable) begin
                     slot     <= slot + 2'd1;
                     lane_ack <= next_ack;
                  end else begin
                     // Leave DATA; the byte loaded here is already idle.
                     state      <= SYNC;
                     slot       <= 2'd0;
                     active_out <= 1'b0;
                  end
               end
               default: begin
                  state <= SYNC;
                  slot  <= 2'd0;
               end
            endcase
         end else begin
            data_serial <= shift_reg[7];
            shift_reg   <= {shift_reg[6:0], 1'b0};
            bit_cnt     <= bit_cnt + 3'd1;
         end
      end
   end

endmodule
